// File: rtl/a_buf_tload_ctrl.sv
// A-operand tile-load controller: turns one tile-load command into per-beat memory reads,
// forwards in-order responses as a_buf write beats, and tracks ping-pong buffer occupancy.
module a_buf_tload_ctrl #(
  parameter int SARRAY_H  = 4,
  parameter int LOAD_W    = SARRAY_H * 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_stride_i,
  input  logic [2:0]        cmd_dw_i,
  input  logic              cmd_buf_id_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [LOAD_W-1:0] mem_rsp_data_i,
  output logic              wr_a_buf_valid_o,
  output logic              wr_a_buf_id_o,
  output logic [2:0]        wr_a_buf_dw_o,
  output logic [LOAD_W-1:0] wr_a_buf_data_o,
  input  logic              rel_valid_i,
  input  logic              rel_id_i,
  output logic [1:0]        buf_full_o,
  output logic              done_valid_o,
  output logic              done_id_o,
  output logic              unexp_rsp_o,
  output logic [2:0]        dbg_state_o
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1; a
  // request's valid and address stay stable until accepted; responses are never back-pressured.

  localparam int CNT_W = $clog2(4 * SARRAY_H + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [2:0] {IDLE, WAIT_BUF, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] stride;
  logic [2:0]        ld_dw;
  logic              ld_id;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rsp_cnt;
  logic [CNT_W-1:0]  beats;
  logic [OUT_W-1:0]  outst;
  logic [2:0]        dw_norm;
  logic              req_fire;
  logic              rsp_ok;
  logic              last_req;
  logic              last_rsp;

  // Anything that is not exactly byte or 2byte one-hot is treated as 4byte.
  assign dw_norm = (cmd_dw_i == 3'b001 || cmd_dw_i == 3'b010) ? cmd_dw_i : 3'b100;

  always_comb begin
    beats = CNT_W'(SARRAY_H);
    case (ld_dw)
      3'b001:  beats = CNT_W'(4 * SARRAY_H);
      3'b010:  beats = CNT_W'(2 * SARRAY_H);
      default: beats = CNT_W'(SARRAY_H);
    endcase
  end

  assign cmd_ready_o     = (state == IDLE) && !rst;
  assign mem_req_valid_o = (state == ISSUE) && (req_cnt < beats) && (outst < OUT_W'(MAX_OUTST));
  assign mem_req_addr_o  = req_addr;
  assign req_fire        = mem_req_valid_o && mem_req_ready_i;
  assign rsp_ok          = mem_rsp_valid_i && (outst != '0);
  assign last_req        = req_fire && (req_cnt == beats - CNT_W'(1));
  assign last_rsp        = rsp_ok && (rsp_cnt == beats - CNT_W'(1));
  assign wr_a_buf_id_o   = ld_id;
  assign wr_a_buf_dw_o   = ld_dw;
  assign dbg_state_o     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      req_addr         <= '0;
      stride           <= '0;
      ld_dw            <= '0;
      ld_id            <= 1'b0;
      req_cnt          <= '0;
      rsp_cnt          <= '0;
      outst            <= '0;
      wr_a_buf_valid_o <= 1'b0;
      wr_a_buf_data_o  <= '0;
      buf_full_o       <= 2'b00;
      done_valid_o     <= 1'b0;
      done_id_o        <= 1'b0;
      unexp_rsp_o      <= 1'b0;
    end else begin
      done_valid_o     <= 1'b0;
      wr_a_buf_valid_o <= rsp_ok;
      unexp_rsp_o      <= mem_rsp_valid_i && (outst == '0);
      if (rsp_ok) begin
        wr_a_buf_data_o <= mem_rsp_data_i;
        rsp_cnt         <= rsp_cnt + CNT_W'(1);
      end
      if (req_fire) begin
        req_cnt  <= req_cnt + CNT_W'(1);
        req_addr <= req_addr + stride;
      end
      if (req_fire && !rsp_ok)      outst <= outst + OUT_W'(1);
      else if (!req_fire && rsp_ok) outst <= outst - OUT_W'(1);
      if (rel_valid_i) buf_full_o[rel_id_i] <= 1'b0;

      case (state)
        IDLE: if (cmd_valid_i) begin
          req_addr <= cmd_addr_i;
          stride   <= cmd_stride_i;
          ld_dw    <= dw_norm;
          ld_id    <= cmd_buf_id_i;
          req_cnt  <= '0;
          rsp_cnt  <= '0;
          state    <= buf_full_o[cmd_buf_id_i] ? WAIT_BUF : ISSUE;
        end
        WAIT_BUF: if (!buf_full_o[ld_id]) state <= ISSUE;
        ISSUE, DRAIN: begin
          // The full flag is written after the release above, so a same-cycle set wins.
          if (last_rsp) begin
            state             <= DONE;
            done_valid_o      <= 1'b1;
            done_id_o         <= ld_id;
            buf_full_o[ld_id] <= 1'b1;
          end else if (state == ISSUE && last_req) begin
            state <= DRAIN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_a_buf_tload_ctrl.sv
// Randomized scoreboard bench for a_buf_tload_ctrl: a memory model, a request/write/done
// monitor and directed tile scenarios around a per-tile address/beat reference model.
module tb_a_buf_tload_ctrl;
  localparam int SARRAY_H  = 4;
  localparam int LOAD_W    = 128;
  localparam int ADDR_W    = 32;
  localparam int MAX_OUTST = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              id;
    logic [2:0]        dw;
    bit                last;
  } exp_req_t;

  typedef struct {
    logic [LOAD_W-1:0] data;
    int                due;
    logic              id;
    logic [2:0]        dw;
    bit                last;
  } pend_t;

  logic              clk, rst;
  logic              cmd_valid_i, cmd_ready_o;
  logic [ADDR_W-1:0] cmd_addr_i, cmd_stride_i;
  logic [2:0]        cmd_dw_i;
  logic              cmd_buf_id_i;
  logic              mem_req_valid_o, mem_req_ready_i;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_rsp_valid_i;
  logic [LOAD_W-1:0] mem_rsp_data_i;
  logic              wr_a_buf_valid_o, wr_a_buf_id_o;
  logic [2:0]        wr_a_buf_dw_o;
  logic [LOAD_W-1:0] wr_a_buf_data_o;
  logic              rel_valid_i, rel_id_i;
  logic [1:0]        buf_full_o;
  logic              done_valid_o, done_id_o, unexp_rsp_o;
  logic [2:0]        dbg_state_o;

  a_buf_tload_ctrl #(.SARRAY_H(SARRAY_H), .LOAD_W(LOAD_W), .ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_stride_i(cmd_stride_i), .cmd_dw_i(cmd_dw_i), .cmd_buf_id_i(cmd_buf_id_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .wr_a_buf_valid_o(wr_a_buf_valid_o), .wr_a_buf_id_o(wr_a_buf_id_o), .wr_a_buf_dw_o(wr_a_buf_dw_o),
    .wr_a_buf_data_o(wr_a_buf_data_o), .rel_valid_i(rel_valid_i), .rel_id_i(rel_id_i),
    .buf_full_o(buf_full_o), .done_valid_o(done_valid_o), .done_id_o(done_id_o),
    .unexp_rsp_o(unexp_rsp_o), .dbg_state_o(dbg_state_o)
  );

  // Scoreboard state
  exp_req_t          exp_addr_q[$];
  pend_t             pend_q[$];
  logic [131:0]      exp_q[$];
  logic              exp_done_q[$];
  int                n_checks = 0, n_errors = 0;
  int                cyc = 0, fire_cnt = 0, lat = 2;
  int                exp_unexp = 0, got_unexp = 0;
  int                rel_req_cnt = 0, rel_done_cnt = 0, unexp_req_cnt = 0, unexp_done_cnt = 0;
  logic              rel_req_id = 1'b0;
  bit                mem_stall = 0, rnd_ready = 0, rel_on_last = 0;
  logic [1:0]        model_full = 2'b00;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: in-order responses after a per-tile latency, plus release/injection driver.
  initial begin
    pend_t e;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    rel_valid_i = 1'b0; rel_id_i = 1'b0;
    forever begin
      bit rel_used;
      @(posedge clk); #1;
      cyc++;
      rel_used = 0;
      mem_req_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_rsp_valid_i = 1'b0;
      rel_valid_i = 1'b0;
      if (!rst && !mem_stall && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        e = pend_q.pop_front();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = e.data;
        exp_q.push_back({e.id, e.dw, e.data});
        if (rel_on_last && e.last) begin
          rel_valid_i = 1'b1; rel_id_i = e.id; rel_used = 1;
        end
      end else if (!rst && unexp_req_cnt != unexp_done_cnt && pend_q.size() == 0) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
        unexp_done_cnt++;
      end
      if (!rel_used && rel_req_cnt != rel_done_cnt) begin
        rel_valid_i = 1'b1; rel_id_i = rel_req_id; rel_done_cnt++;
      end
    end
  end

  // Monitor: requests, writes, done pulses and unexpected-response pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req_valid_o && mem_req_ready_i) begin
          fire_cnt++;
          if (exp_addr_q.size() == 0) chk("req_unexpected", 1, 0);
          else begin
            exp_req_t r;
            pend_t p;
            r = exp_addr_q.pop_front();
            chk("req_addr", mem_req_addr_o, r.addr);
            p.data = {$urandom, $urandom, $urandom, $urandom};
            p.due = cyc + lat; p.id = r.id; p.dw = r.dw; p.last = r.last;
            pend_q.push_back(p);
          end
        end
        if (wr_a_buf_valid_o) begin
          if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
          else chk("wr_beat", {wr_a_buf_id_o, wr_a_buf_dw_o, wr_a_buf_data_o}, exp_q.pop_front());
        end
        if (done_valid_o) begin
          if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            logic d;
            d = exp_done_q.pop_front();
            chk("done_id", done_id_o, d);
            chk("done_full", buf_full_o[d], 1'b1);
          end
        end
        if (unexp_rsp_o) got_unexp++;
      end
    end
  end

  // Driver tasks. The reference model derives beat count and addresses from the command.
  task automatic issue_cmd(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s,
                           input logic [2:0] dw, input logic id, input int l);
    int bytes, n;
    logic [2:0] edw;
    exp_req_t r;
    bytes = (dw == 3'b001) ? 1 : (dw == 3'b010) ? 2 : 4;
    n     = SARRAY_H * 4 / bytes;
    edw   = (bytes == 1) ? 3'b001 : (bytes == 2) ? 3'b010 : 3'b100;
    lat   = l;
    for (int k = 0; k < n; k++) begin
      r.addr = a + 32'(k) * s; r.id = id; r.dw = edw; r.last = (k == n - 1);
      exp_addr_q.push_back(r);
    end
    exp_done_q.push_back(id);
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_stride_i = s; cmd_dw_i = dw; cmd_buf_id_i = id;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cmd_ready_o) break;
      if (t == 199) chk("cmd_accept_timeout", 0, 1);
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input logic id);
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_done_q.size() == 0) break;
      if (t == 2999) chk("done_timeout", 0, 1);
    end
    model_full[id] = 1'b1;
    @(negedge clk);
    chk("buf_full_after_done", buf_full_o, model_full);
  endtask

  task automatic release_buf(input logic id);
    rel_req_id = id;
    rel_req_cnt++;
    repeat (2) @(negedge clk);
    model_full[id] = 1'b0;
    chk("buf_full_after_rel", buf_full_o, model_full);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready_o, 1'b0);
    chk({tag, "_req_valid"}, mem_req_valid_o, 1'b0);
    chk({tag, "_req_addr"}, mem_req_addr_o, '0);
    chk({tag, "_wr_valid"}, wr_a_buf_valid_o, 1'b0);
    chk({tag, "_wr_data"}, wr_a_buf_data_o, '0);
    chk({tag, "_buf_full"}, buf_full_o, 2'b00);
    chk({tag, "_done"}, done_valid_o, 1'b0);
    chk({tag, "_unexp"}, unexp_rsp_o, 1'b0);
  endtask

  initial begin
    int f0;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_stride_i = '0; cmd_dw_i = '0; cmd_buf_id_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready_o, 1'b1);

    // 4byte tile into id0, then a byte tile into id1
    issue_cmd(32'h1000, 32'h40, 3'b100, 1'b0, 2);
    wait_done(1'b0);
    issue_cmd(32'h2000, 32'h10, 3'b001, 1'b1, 2);
    wait_done(1'b1);

    // Load into a full buffer stalls until released; release of the other id mid-load;
    // a release colliding with the completion of the same id keeps it full.
    issue_cmd(32'h3000, 32'h20, 3'b100, 1'b0, 2);
    f0 = fire_cnt;
    repeat (10) @(negedge clk);
    chk("waitbuf_no_fire", fire_cnt, f0);
    chk("waitbuf_req_valid", mem_req_valid_o, 1'b0);
    rel_on_last = 1;
    release_buf(1'b0);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (fire_cnt > f0) break;
      if (t == 5) chk("waitbuf_release_timeout", 0, 1);
    end
    release_buf(1'b1);
    wait_done(1'b0);
    rel_on_last = 0;

    // Stalled responses cap outstanding reads
    release_buf(1'b0);
    mem_stall = 1;
    f0 = fire_cnt;
    issue_cmd(32'h4000, 32'h10, 3'b001, 1'b0, 1);
    repeat (20) @(negedge clk);
    chk("outst_cap_fires", fire_cnt - f0, MAX_OUTST);
    chk("outst_cap_req_valid", mem_req_valid_o, 1'b0);
    mem_stall = 0;
    wait_done(1'b0);

    // Address wraps modulo 2^32
    release_buf(1'b0);
    issue_cmd(32'hFFFF_FFC0, 32'h40, 3'b100, 1'b0, 3);
    wait_done(1'b0);

    // Response with nothing outstanding while idle
    exp_unexp++;
    unexp_req_cnt++;
    repeat (4) @(negedge clk);
    chk("unexp_pulse", got_unexp, exp_unexp);

    // Randomized tiles with random ready back-pressure and latency
    rnd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      logic id;
      id = 1'($urandom_range(0, 1));
      if (model_full[id]) release_buf(id);
      issue_cmd($urandom, $urandom, 3'($urandom_range(0, 7)), id, $urandom_range(1, 4));
      wait_done(id);
    end
    rnd_ready = 0;

    // Reset in the middle of a load
    if (model_full[0]) release_buf(1'b0);
    mem_stall = 1;
    f0 = fire_cnt;
    issue_cmd(32'h5000, 32'h10, 3'b001, 1'b0, 1);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (fire_cnt >= f0 + 3) break;
      if (t == 49) chk("mid_reset_fire_timeout", 0, 1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    exp_addr_q.delete(); pend_q.delete(); exp_q.delete(); exp_done_q.delete();
    model_full = 2'b00;
    mem_stall = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_mid_reset", cmd_ready_o, 1'b1);
    issue_cmd(32'h6000, 32'h80, 3'b010, 1'b1, 2);
    wait_done(1'b1);

    repeat (5) @(negedge clk);
    chk("left_exp_addr", exp_addr_q.size(), 0);
    chk("left_exp_wr", exp_q.size(), 0);
    chk("left_exp_done", exp_done_q.size(), 0);
    chk("unexp_total", got_unexp, exp_unexp);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
